pc_gen: RTL and testbench

Parametrised program-counter generator that supersedes the fixed PC+4 adder in the RV32I fetch path. It owns the architectural PC register and applies the next-PC increment internally. It also handles redirects from branch/jump resolution, fetch back-pressure through a valid/ready handshake, halt, and a saturating fetch counter. It sits between the control/branch unit and the instruction memory port.

---
 rtl/pc_gen.sv | 149 ++++++++++++++
 tb/tb_pc_gen.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, redirects, fetch counter.
// Optional misaligned-redirect trap is compiled in with PC_MISALIGN_TRAP_EN.
module pc_gen #(
    parameter int unsigned         XLEN         = 32,
    parameter int unsigned         INC          = 4,
    parameter logic [XLEN-1:0]     RESET_VECTOR = 32'h0100_0000,
    parameter logic [XLEN-1:0]     TRAP_VECTOR  = 32'h0100_0000,
    parameter int unsigned         CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             halt_req,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             fetch_valid,
    output logic             halted,
    output logic             misalign_err,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC_V - 1'b1);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic             accept;
    logic             tgt_misaligned;
    logic [XLEN-1:0]  tgt_aligned;

    assign accept         = fetch_valid_q & fetch_ready;
    assign tgt_misaligned = |(redirect_target & ~ALIGN_MASK);
    // Low bits taken from the (aligned) trap vector are zero, so this is a plain mask.
    assign tgt_aligned    = (redirect_target & ALIGN_MASK)
                          | (TRAP_VECTOR & ~ALIGN_MASK);

`ifdef PC_MISALIGN_TRAP_EN
    logic             misalign_err_q, misalign_err_d;
    logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_err_d  = 1'b0;
        misalign_addr_d = misalign_addr_q;
`endif

        if (accept && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 1'b1;
        end

        unique case (state_q)
            BOOT: begin
                state_d       = RUN;
                fetch_valid_d = 1'b1;
            end
            RUN: begin
                if (halt_req) begin
                    state_d       = HALT;
                    fetch_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (tgt_misaligned) begin
                        pc_d            = TRAP_VECTOR;
                        misalign_err_d  = 1'b1;
                        misalign_addr_d = redirect_target;
                    end else begin
                        pc_d = redirect_target;
                    end
`else
                    pc_d = tgt_aligned;
`endif
                end else if (!stall && accept) begin
                    pc_d = pc_q + INC_V;
                end
            end
            HALT: begin
                fetch_valid_d = 1'b0;
                halted_d      = 1'b1;
            end
            default: begin
                state_d       = BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_err_q  <= misalign_err_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign misalign_err  = misalign_err_q;
    assign misalign_addr = misalign_addr_q;
`else
    logic unused_misalign;
    assign unused_misalign = tgt_misaligned;
    assign misalign_err    = 1'b0;
    assign misalign_addr   = '0;
`endif

    assign pc          = pc_q;
    assign pc_plus_inc = pc_q + INC_V;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, back-pressure, redirect, misalign, wrap,
// halt, asynchronous reset and (on a CNT_W=4 instance) counter saturation.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        fetch_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] misalign_addr;
    logic [31:0] fetch_count;

    logic        s_rst;
    logic        s_ready;
    logic [31:0] s_pc;
    logic [31:0] s_pc_plus_inc;
    logic        s_fetch_valid;
    logic        s_halted;
    logic        s_misalign_err;
    logic [31:0] s_misalign_addr;
    logic [3:0]  s_fetch_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .fetch_ready     (fetch_ready),
        .pc              (pc),
        .pc_plus_inc     (pc_plus_inc),
        .fetch_valid     (fetch_valid),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .misalign_addr   (misalign_addr),
        .fetch_count     (fetch_count)
    );

    pc_gen #(.CNT_W(4)) u_sat (
        .clk             (clk),
        .rst             (s_rst),
        .stall           (1'b0),
        .redirect        (1'b0),
        .redirect_target (32'h0),
        .halt_req        (1'b0),
        .fetch_ready     (s_ready),
        .pc              (s_pc),
        .pc_plus_inc     (s_pc_plus_inc),
        .fetch_valid     (s_fetch_valid),
        .halted          (s_halted),
        .misalign_err    (s_misalign_err),
        .misalign_addr   (s_misalign_addr),
        .fetch_count     (s_fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_target = 32'h0; halt_req = 1'b0; fetch_ready = 1'b0;
        step(); step();
        checks++;
        if (pc !== 32'h0100_0000 || fetch_valid !== 1'b0 || halted !== 1'b0
            || fetch_count !== 32'd0 || misalign_err !== 1'b0
            || misalign_addr !== 32'd0 || pc_plus_inc !== 32'h0100_0004) begin
            failures++;
            $display("FAIL reset_vals: pc=%h fv=%b h=%b cnt=%0d me=%b ma=%h ppi=%h",
                     pc, fetch_valid, halted, fetch_count, misalign_err,
                     misalign_addr, pc_plus_inc);
        end
        rst = 1'b0;
        fetch_ready = 1'b1;
        #2;
        checks++;
        if (fetch_valid !== 1'b0 || pc !== 32'h0100_0000) begin
            failures++;
            $display("FAIL boot_cycle: fv=%b pc=%h want fv=0 pc=01000000",
                     fetch_valid, pc);
        end
        step();
        checks++;
        if (fetch_valid !== 1'b1 || pc !== 32'h0100_0000
            || fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL run_entry: fv=%b pc=%h cnt=%0d want 1/01000000/0",
                     fetch_valid, pc, fetch_count);
        end
        step();
        checks++;
        if (pc !== 32'h0100_0004) begin
            failures++;
            $display("FAIL inc1: pc=%h want 01000004", pc);
        end
        step();
        checks++;
        if (pc !== 32'h0100_0008 || fetch_count !== 32'd2) begin
            failures++;
            $display("FAIL inc2: pc=%h cnt=%0d want 01000008/2", pc, fetch_count);
        end
    endtask

    task automatic test_backpressure();
        step(); step();
        checks++;
        if (pc !== 32'h0100_0010 || fetch_count !== 32'd4) begin
            failures++;
            $display("FAIL bp_pre: pc=%h cnt=%0d want 01000010/4", pc, fetch_count);
        end
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'h0100_0010 || fetch_count !== 32'd4) begin
                failures++;
                $display("FAIL bp_hold%0d: pc=%h cnt=%0d want 01000010/4",
                         i, pc, fetch_count);
            end
        end
        fetch_ready = 1'b1;
        step();
        checks++;
        if (pc !== 32'h0100_0014 || fetch_count !== 32'd5) begin
            failures++;
            $display("FAIL bp_release: pc=%h cnt=%0d want 01000014/5",
                     pc, fetch_count);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h0100_0200;
        step();
        checks++;
        if (pc !== 32'h0100_0200 || pc_plus_inc !== 32'h0100_0204) begin
            failures++;
            $display("FAIL redir_stall: pc=%h ppi=%h want 01000200/01000204",
                     pc, pc_plus_inc);
        end
        redirect = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if (pc !== 32'h0100_0204) begin
            failures++;
            $display("FAIL redir_after: pc=%h want 01000204", pc);
        end
        stall = 1'b1;
        step();
        checks++;
        if (pc !== 32'h0100_0204) begin
            failures++;
            $display("FAIL stall_hold: pc=%h want 01000204", pc);
        end
        stall = 1'b0;
    endtask

    task automatic test_misalign();
        redirect = 1'b1;
        redirect_target = 32'h0100_0102;
        step();
        redirect = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        checks++;
        if (pc !== 32'h0100_0000 || misalign_err !== 1'b1
            || misalign_addr !== 32'h0100_0102) begin
            failures++;
            $display("FAIL misalign_trap: pc=%h me=%b ma=%h want 01000000/1/01000102",
                     pc, misalign_err, misalign_addr);
        end
        step();
        checks++;
        if (misalign_err !== 1'b0 || pc !== 32'h0100_0004
            || misalign_addr !== 32'h0100_0102) begin
            failures++;
            $display("FAIL misalign_pulse: me=%b pc=%h ma=%h want 0/01000004/01000102",
                     misalign_err, pc, misalign_addr);
        end
`else
        checks++;
        if (pc !== 32'h0100_0100 || misalign_err !== 1'b0
            || misalign_addr !== 32'h0) begin
            failures++;
            $display("FAIL misalign_mask: pc=%h me=%b ma=%h want 01000100/0/0",
                     pc, misalign_err, misalign_addr);
        end
        step();
        checks++;
        if (pc !== 32'h0100_0104 || misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL misalign_next: pc=%h me=%b want 01000104/0",
                     pc, misalign_err);
        end
`endif
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus_inc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pre: pc=%h ppi=%h want fffffffc/0", pc, pc_plus_inc);
        end
        step();
        checks++;
        if (pc !== 32'h0 || fetch_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap: pc=%h fv=%b want 0/1", pc, fetch_valid);
        end
    endtask

    task automatic test_halt();
        logic [31:0] pc_before;
        step();
        pc_before = pc;
        halt_req = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h0100_0400;
        step();
        halt_req = 1'b0;
        redirect = 1'b0;
        checks++;
        if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== pc_before) begin
            failures++;
            $display("FAIL halt_enter: h=%b fv=%b pc=%h want 1/0/%h",
                     halted, fetch_valid, pc, pc_before);
        end
        redirect = 1'b1;
        for (int i = 0; i < 3; i++) step();
        redirect = 1'b0;
        checks++;
        if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== pc_before) begin
            failures++;
            $display("FAIL halt_sticky: h=%b fv=%b pc=%h want 1/0/%h",
                     halted, fetch_valid, pc, pc_before);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || fetch_valid !== 1'b0 || pc !== 32'h0100_0000
            || fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL async_rst: h=%b fv=%b pc=%h cnt=%0d want 0/0/01000000/0",
                     halted, fetch_valid, pc, fetch_count);
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (pc !== 32'h0100_0004 || fetch_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_recover: pc=%h fv=%b want 01000004/1", pc, fetch_valid);
        end
    endtask

    task automatic test_saturation();
        s_ready = 1'b1;
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        step();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                checks++;
                if (s_fetch_count !== 4'd14) begin
                    failures++;
                    $display("FAIL sat_14: cnt=%0d want 14", s_fetch_count);
                end
            end
        end
        checks++;
        if (s_fetch_count !== 4'd15 || s_pc !== 32'h0100_0050) begin
            failures++;
            $display("FAIL sat_20: cnt=%0d pc=%h want 15/01000050",
                     s_fetch_count, s_pc);
        end
    endtask

    initial begin
        s_rst = 1'b1;
        s_ready = 1'b0;
        test_reset();
        test_backpressure();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_halt();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
